multicycle_ctrl: RTL and testbench

//   Multi-cycle sequencer for the MIPS datapath (PC/NPC/IM/GRF/EXT/ALU/DM/muxes).

---
 rtl/multicycle_ctrl.sv | 154 +++++++++++++++
 tb/tb_multicycle_ctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS sequencer: latches Op/Func in FETCH, walks FETCH/DECODE/EXEC/MEM/WB
// and drives datapath selects plus single-cycle PC/GRF/DM write strobes.
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Op,
  input  logic [5:0]       Func,
  output logic             PCWrite,
  output logic             IRWrite,
  output logic             RegWrite,
  output logic             MemWrite,
  output logic [2:0]       RegDstSel,
  output logic [2:0]       ALUSrcSel,
  output logic [2:0]       toRegSel,
  output logic [2:0]       NPCOp,
  output logic [3:0]       ALUOp,
  output logic [2:0]       EXTOp,
  output logic [2:0]       state,
  output logic             instr_done,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    I_ADDU, I_SUBU, I_JR, I_ORI, I_LUI, I_LW, I_SW, I_BEQ, I_JAL, I_NOP
  } instr_e;

  state_e           state_q, state_d;
  logic [5:0]       op_q, func_q;
  logic [CNT_W-1:0] retired_q;

  instr_e     kind;
  state_e     last_st;
  logic [2:0] rd_sel, as_sel, tr_sel, npc_sel, ext_sel;
  logic [3:0] alu_sel;
  logic       active, last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      op_q      <= '0;
      func_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH) begin
        op_q   <= Op;
        func_q <= Func;
      end
      if (PCWrite) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    kind = I_NOP;
    case (op_q)
      6'b000000: begin
        case (func_q)
          6'b100001: kind = I_ADDU;
          6'b100011: kind = I_SUBU;
          6'b001000: kind = I_JR;
          default:   kind = I_NOP;
        endcase
      end
      6'b001101: kind = I_ORI;
      6'b001111: kind = I_LUI;
      6'b100011: kind = I_LW;
      6'b101011: kind = I_SW;
      6'b000100: kind = I_BEQ;
      6'b000011: kind = I_JAL;
      default:   kind = I_NOP;
    endcase
  end

  always_comb begin
    rd_sel  = '0;
    as_sel  = '0;
    tr_sel  = '0;
    npc_sel = '0;
    ext_sel = '0;
    alu_sel = '0;
    last_st = S_DECODE;
    case (kind)
      I_ADDU: begin rd_sel = 3'd1; last_st = S_WB; end
      I_SUBU: begin rd_sel = 3'd1; alu_sel = 4'd1; last_st = S_WB; end
      I_JR:   begin npc_sel = 3'd3; last_st = S_EXEC; end
      I_ORI:  begin as_sel = 3'd1; alu_sel = 4'd2; last_st = S_WB; end
      I_LUI:  begin tr_sel = 3'd2; ext_sel = 3'd2; last_st = S_WB; end
      I_LW:   begin as_sel = 3'd1; tr_sel = 3'd1; ext_sel = 3'd1; last_st = S_WB; end
      I_SW:   begin as_sel = 3'd1; ext_sel = 3'd1; last_st = S_MEM; end
      I_BEQ:  begin alu_sel = 4'd1; npc_sel = 3'd1; last_st = S_EXEC; end
      I_JAL:  begin rd_sel = 3'd2; tr_sel = 3'd3; npc_sel = 3'd2; last_st = S_WB; end
      default: last_st = S_DECODE;
    endcase
  end

  always_comb begin
    state_d = S_FETCH;
    IRWrite = 1'b0;
    active  = 1'b0;
    case (state_q)
      S_FETCH: begin
        IRWrite = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        active = 1'b1;
        if (kind == I_NOP)      state_d = S_FETCH;
        else if (kind == I_JAL) state_d = S_WB;
        else                    state_d = S_EXEC;
      end
      S_EXEC: begin
        active = 1'b1;
        if (kind == I_BEQ || kind == I_JR)     state_d = S_FETCH;
        else if (kind == I_LW || kind == I_SW) state_d = S_MEM;
        else                                   state_d = S_WB;
      end
      S_MEM: begin
        active  = 1'b1;
        state_d = (kind == I_LW) ? S_WB : S_FETCH;
      end
      S_WB: begin
        active  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by reset so an aborted instruction never commits.
  assign last       = active && (state_q == last_st);
  assign PCWrite    = last && !reset;
  assign instr_done = PCWrite;
  assign RegWrite   = (state_q == S_WB) && !reset;
  assign MemWrite   = (state_q == S_MEM) && (kind == I_SW) && !reset;
  assign NPCOp      = last ? npc_sel : '0;
  assign RegDstSel  = active ? rd_sel  : '0;
  assign ALUSrcSel  = active ? as_sel  : '0;
  assign toRegSel   = active ? tr_sel  : '0;
  assign ALUOp      = active ? alu_sel : '0;
  assign EXTOp      = active ? ext_sel : '0;
  assign state      = state_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: per-instruction reference model built from
// the opcode table and state paths, directed scenarios plus a randomized stream.
module tb_multicycle_ctrl;

  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [5:0]    Op, Func;
  logic          PCWrite, IRWrite, RegWrite, MemWrite, instr_done;
  logic [2:0]    RegDstSel, ALUSrcSel, toRegSel, NPCOp, EXTOp, state;
  logic [3:0]    ALUOp;
  logic [CW-1:0] retired;

  int checks   = 0;
  int failures = 0;
  int exp_ret  = 0;

  multicycle_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .Op(Op), .Func(Func),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .RegDstSel(RegDstSel), .ALUSrcSel(ALUSrcSel), .toRegSel(toRegSel), .NPCOp(NPCOp),
    .ALUOp(ALUOp), .EXTOp(EXTOp), .state(state), .instr_done(instr_done),
    .retired(retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    int         st[5];
    logic [2:0] rd, as, tr, npc, ext;
    logic [3:0] alu;
    bit         wreg, wmem;
  } exp_t;

  // Reference: opcode table -> selects, path kind -> visited state list.
  function automatic exp_t model(input logic [5:0] op, input logic [5:0] func);
    exp_t e;
    int   path;
    e.rd = 0; e.as = 0; e.tr = 0; e.npc = 0; e.ext = 0; e.alu = 0;
    e.wreg = 0; e.wmem = 0;
    path = 0;
    if (op == 6'h00 && func == 6'h21)      begin e.rd = 1; path = 2; end
    else if (op == 6'h00 && func == 6'h23) begin e.rd = 1; e.alu = 1; path = 2; end
    else if (op == 6'h00 && func == 6'h08) begin e.npc = 3; path = 1; end
    else if (op == 6'h0D) begin e.as = 1; e.alu = 2; path = 2; end
    else if (op == 6'h0F) begin e.tr = 2; e.ext = 2; path = 2; end
    else if (op == 6'h23) begin e.as = 1; e.tr = 1; e.ext = 1; path = 3; end
    else if (op == 6'h2B) begin e.as = 1; e.ext = 1; path = 4; end
    else if (op == 6'h04) begin e.alu = 1; e.npc = 1; path = 1; end
    else if (op == 6'h03) begin e.rd = 2; e.tr = 3; e.npc = 2; path = 5; end
    for (int i = 0; i < 5; i++) e.st[i] = 0;
    e.st[1] = 1;
    case (path)
      0: e.n = 2;
      1: begin e.n = 3; e.st[2] = 2; end
      2: begin e.n = 4; e.st[2] = 2; e.st[3] = 4; end
      3: begin e.n = 5; e.st[2] = 2; e.st[3] = 3; e.st[4] = 4; end
      4: begin e.n = 4; e.st[2] = 2; e.st[3] = 3; end
      default: begin e.n = 3; e.st[2] = 4; end
    endcase
    e.wreg = (path == 2 || path == 3 || path == 5);
    e.wmem = (path == 4);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction from FETCH, scoring every cycle; reports the cycle of PCWrite.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] func, output int cyc,
                           output logic [2:0] rd_seen, output logic [2:0] tr_seen);
    exp_t        e;
    logic [26:0] obs, exp;
    logic [2:0]  ns;
    logic        last;
    e = model(op, func);
    cyc = 0; rd_seen = 0; tr_seen = 0;
    Op = op; Func = func;
    for (int k = 0; k < e.n; k++) begin
      last = (k == e.n - 1);
      ns   = 3'(e.st[k]);
      if (k == 0)
        exp = {ns, 1'b1, 4'b0, 12'b0, 4'b0, 3'b0};
      else
        exp = {ns, 1'b0, last, last, e.wreg && ns == 3'd4, e.wmem && ns == 3'd3,
               e.rd, e.as, e.tr, last ? e.npc : 3'd0, e.alu, e.ext};
      obs = {state, IRWrite, PCWrite, instr_done, RegWrite, MemWrite,
             RegDstSel, ALUSrcSel, toRegSel, NPCOp, ALUOp, EXTOp};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL cycle op=%h func=%h k=%0d got=%h want=%h", op, func, k, obs, exp);
      end
      checks++;
      if (retired !== CW'(exp_ret)) begin
        failures++;
        $display("FAIL retired_hold k=%0d got=%0d want=%0d", k, retired, CW'(exp_ret));
      end
      if (PCWrite === 1'b1 && cyc == 0) cyc = k + 1;
      if (RegWrite === 1'b1) begin rd_seen = RegDstSel; tr_seen = toRegSel; end
      step();
      Op = 6'($urandom); Func = 6'($urandom);
    end
    exp_ret++;
  endtask

  task automatic test_reset();
    reset = 1'b1; Op = '0; Func = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({PCWrite, RegWrite, MemWrite} !== 3'b000) begin
        failures++;
        $display("FAIL reset_strobes got=%b want=000", {PCWrite, RegWrite, MemWrite});
      end
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({state, IRWrite, PCWrite, RegWrite, MemWrite, NPCOp, RegDstSel, toRegSel} !== {3'd0, 1'b1, 3'b000, 9'd0}) begin
      failures++;
      $display("FAIL reset_state state=%0d IRWrite=%b strobes=%b", state, IRWrite,
               {PCWrite, RegWrite, MemWrite});
    end
    checks++;
    if (retired !== '0) begin
      failures++;
      $display("FAIL reset_retired got=%0d want=0", retired);
    end
    exp_ret = 0;
  endtask

  task automatic test_addu();
    int cyc; logic [2:0] rd, tr;
    run_instr(6'h00, 6'h21, cyc, rd, tr);
    checks++;
    if (cyc !== 4 || rd !== 3'd1) begin
      failures++;
      $display("FAIL addu_len cyc=%0d want=4 RegDstSel=%0d want=1", cyc, rd);
    end
  endtask

  task automatic test_lw_sw();
    int cyc; logic [2:0] rd, tr;
    run_instr(6'h23, 6'h15, cyc, rd, tr);
    checks++;
    if (cyc !== 5 || tr !== 3'd1) begin
      failures++;
      $display("FAIL lw_len cyc=%0d want=5 toRegSel=%0d want=1", cyc, tr);
    end
    run_instr(6'h2B, 6'h00, cyc, rd, tr);
    checks++;
    if (cyc !== 4) begin
      failures++;
      $display("FAIL sw_len cyc=%0d want=4", cyc);
    end
  endtask

  task automatic test_branch_jumps();
    int cyc; logic [2:0] rd, tr;
    run_instr(6'h04, 6'h3F, cyc, rd, tr);
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL beq_len cyc=%0d want=3", cyc); end
    run_instr(6'h03, 6'h00, cyc, rd, tr);
    checks++;
    if (cyc !== 3 || rd !== 3'd2 || tr !== 3'd3) begin
      failures++;
      $display("FAIL jal_len cyc=%0d want=3 RegDstSel=%0d want=2 toRegSel=%0d want=3", cyc, rd, tr);
    end
    run_instr(6'h00, 6'h08, cyc, rd, tr);
    checks++;
    if (cyc !== 3) begin failures++; $display("FAIL jr_len cyc=%0d want=3", cyc); end
  endtask

  task automatic test_unknown();
    int cyc; logic [2:0] rd, tr;
    run_instr(6'h3F, 6'h21, cyc, rd, tr);
    checks++;
    if (cyc !== 2) begin failures++; $display("FAIL unknown_len cyc=%0d want=2", cyc); end
    checks++;
    if (retired !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL unknown_retired got=%0d want=%0d", retired, CW'(exp_ret));
    end
  endtask

  task automatic test_random();
    int cyc; logic [2:0] rd, tr;
    logic [5:0] ops [9] = '{6'h00, 6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h03};
    logic [5:0] fns [3] = '{6'h21, 6'h23, 6'h08};
    logic [5:0] op, fn;
    int idx;
    for (int i = 0; i < 60; i++) begin
      idx = int'($urandom_range(0, 9));
      if (idx == 9) begin op = 6'($urandom); fn = 6'($urandom); end
      else begin
        op = ops[idx];
        fn = (idx < 3) ? fns[idx] : 6'($urandom);
      end
      run_instr(op, fn, cyc, rd, tr);
    end
    checks++;
    if (retired !== CW'(exp_ret)) begin
      failures++;
      $display("FAIL random_retired_wrap got=%0d want=%0d", retired, CW'(exp_ret));
    end
  endtask

  task automatic test_reset_mid();
    Op = 6'h23; Func = 6'h00;
    step(); step(); step();
    checks++;
    if (state !== 3'd3) begin failures++; $display("FAIL mid_in_mem state=%0d want=3", state); end
    reset = 1'b1;
    #1;
    checks++;
    if ({RegWrite, MemWrite, PCWrite} !== 3'b000) begin
      failures++;
      $display("FAIL mid_strobes got=%b want=000", {RegWrite, MemWrite, PCWrite});
    end
    step();
    reset = 1'b0;
    #1;
    exp_ret = 0;
    checks++;
    if ({state, RegWrite, retired} !== {3'd0, 1'b0, CW'(0)}) begin
      failures++;
      $display("FAIL mid_abort state=%0d RegWrite=%b retired=%0d want 0/0/0", state, RegWrite, retired);
    end
  endtask

  initial begin
    test_reset();
    test_addu();
    test_lw_sw();
    test_branch_jumps();
    test_unknown();
    test_random();
    test_reset_mid();
    test_addu();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
